// File: rtl/sym_fir_param.sv
// Odd-length linear-phase FIR with pre-add symmetry folding and
// double-buffered run-time coefficients; 3-cycle sample-to-output latency.
module sym_fir_param #(
  parameter int N_TAPS = 31,
  parameter int DW     = 18,
  parameter int CW     = 18,
  parameter int AW     = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] x_in,
  input  logic                 x_valid,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_data,
  input  logic                 coef_commit,
  output logic signed [DW-1:0] y,
  output logic                 y_valid,
  output logic                 sat_flag
);

  localparam int NC = (N_TAPS + 1) / 2;
  localparam int LG = $clog2(NC);
  localparam int MW = DW + CW;
  localparam int AC = MW + LG;
  localparam int SW = AC - (CW - 1);

  logic signed [DW-1:0] x_q   [N_TAPS];
  logic signed [DW-1:0] p_q   [NC];
  logic signed [MW-1:0] m_q   [NC];
  logic signed [CW-1:0] shd_q [NC];
  logic signed [CW-1:0] act_q [NC];

  logic xv_q, pv_q, mv_q, yv_q, sat_q;
  logic signed [DW-1:0] y_q, y_d;
  logic signed [AC-1:0] acc_d;
  logic signed [SW-1:0] sh_d;
  logic                 sat_d;

  // Commit copies the pre-edge shadow, so a same-cycle write stays shadow-only.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NC; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NC; k++) begin
        if (coef_commit)
          act_q[k] <= shd_q[k];
        if (coef_we && coef_addr == AW'(k))
          shd_q[k] <= coef_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xv_q <= 1'b0;
      for (int i = 0; i < N_TAPS; i++)
        x_q[i] <= '0;
    end else begin
      xv_q <= x_valid;
      if (x_valid) begin
        x_q[0] <= x_in >>> 1;
        for (int i = 1; i < N_TAPS; i++)
          x_q[i] <= x_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pv_q <= 1'b0;
      mv_q <= 1'b0;
      for (int k = 0; k < NC; k++) begin
        p_q[k] <= '0;
        m_q[k] <= '0;
      end
    end else begin
      pv_q <= xv_q;
      mv_q <= pv_q;
      for (int k = 0; k < NC - 1; k++)
        p_q[k] <= x_q[k] + x_q[N_TAPS-1-k];
      p_q[NC-1] <= x_q[NC-1];
      for (int k = 0; k < NC; k++)
        m_q[k] <= MW'(p_q[k]) * MW'(act_q[k]);
    end
  end

  always_comb begin
    acc_d = '0;
    for (int k = 0; k < NC; k++)
      acc_d = acc_d + AC'(m_q[k]);
    sh_d  = SW'(acc_d >>> (CW - 1));
    sat_d = !((&sh_d[SW-1:DW-1]) || !(|sh_d[SW-1:DW-1]));
    y_d   = sh_d[DW-1:0];
    if (sat_d)
      y_d = sh_d[SW-1] ? {1'b1, {(DW-1){1'b0}}}
                       : {1'b0, {(DW-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q   <= '0;
      yv_q  <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      yv_q <= mv_q;
      if (mv_q) begin
        y_q <= y_d;
        if (sat_d)
          sat_q <= 1'b1;
      end
    end
  end

  assign y        = y_q;
  assign y_valid  = yv_q;
  assign sat_flag = sat_q;

endmodule

// File: doc/sym_fir_param.md
Name: sym_fir_param

Overview:
- Parametrised, odd-length, linear-phase (symmetric) FIR filter with run-time loadable, double-buffered coefficients.
- Sits in the DSP datapath between the sample source and the DAC/next stage. It is the general successor to the fixed 31-tap, switch-selected window filters.
- Samples enter on a per-sample valid strobe. Coefficients are written into a shadow bank and committed atomically.

Parameters:
- N_TAPS, 31, filter length; must be odd and >= 3; NC = (N_TAPS+1)/2 unique coefficients.
- DW, 18, signed sample width in and out (Q1.(DW-1)).
- CW, 18, signed coefficient width (Q1.(CW-1)).
- AW, 5, coefficient address width; 2^AW >= NC.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- x_in  in  DW  signed input sample.
- x_valid  in  1  accept x_in this cycle; delay line shifts only when high.
- coef_we  in  1  write coef_data into shadow bank at coef_addr.
- coef_addr  in  AW  shadow index; 0 = outer tap (h[0] = h[N_TAPS-1]), NC-1 = centre tap.
- coef_data  in  CW  signed coefficient.
- coef_commit  in  1  copy entire shadow bank into active bank.
- y  out  DW  signed filtered output.
- y_valid  out  1  one-cycle strobe: y updated.
- sat_flag  out  1  sticky; set when any output saturates.

Behaviour:
- Reset, synchronous, active-high:
  - Delay line, pre-add and product registers, y, y_valid, sat_flag all go to 0.
  - Shadow and active banks are both cleared to 0.
  - Reset mid-stream discards in-flight samples; no y_valid until new samples traverse the pipe.
- Delay line x[0..N_TAPS-1]:
  - On x_valid: x[0] <= x_in >>> 1 (arithmetic, 1 bit pre-add headroom); x[i] <= x[i-1].
  - Without x_valid: holds.
- Stage P (registered every cycle):
  - For k < NC-1: p[k] = x[k] + x[N_TAPS-1-k], DW bits. Cannot overflow because of the halved input.
  - p[NC-1] = x[NC-1].
- Stage M (registered every cycle): m[k] = p[k] * active[k], full DW+CW bits.
- Sum and output:
  - Combinational adder tree: acc = sum of m[k], width DW+CW+ceil(log2 NC), no truncation.
  - Output register: y <= sat(acc >>> (CW-1)) to DW bits, floor rounding.
  - Clamp range: max 2^(DW-1)-1, min -2^(DW-1).
  - Any clamp sets sat_flag, which is cleared only by reset.
- Valid pipeline: valid bits track x_valid through P, M and output. y_valid pulses exactly 3 cycles after the edge that accepted the sample. y holds between pulses.
- Back-to-back x_valid every cycle gives one y per cycle. Idle gaps of any length are allowed.
- Coefficients:
  - coef_we with coef_addr >= NC is ignored.
  - coef_commit: active <= shadow, using shadow contents before this edge.
  - Simultaneous coef_we + coef_commit: the write lands in shadow only; it is not committed that cycle.
  - The new active bank affects M from the next edge. Samples already past M keep their old products. No flush.
  - Writes without a commit never change the output.

Test Plan:
- Reset values: after reset, drive x_valid=1 with x_in=65536 for 40 cycles -> y=0 throughout (all coefficients are 0). sat_flag=0.
- Centre tap: write addr 15 = 131071, commit, then send an impulse x=65536 followed by zeros -> y=32767 exactly once, on the 16th output (impulse index + 15), 3 cycles after acceptance. All other y=0.
- Symmetry: addr 0 = 65536, commit, impulse x=65536 -> y=16384 on output indices 0 and 30 only. Repeat with x=-65536 -> y=-16384 at the same indices.
- Saturation: all NC coefficients = 131071, constant x=131071 -> y clamps to 131071 and sat_flag=1. With x=-131072 -> y=-131072. sat_flag persists after x returns to 0.
- Commit timing: write addr 15 = 131071 and commit; in the same cycle as a later commit, write addr 15 = 0. Then with constant x=65536 -> y stays 32767. A second commit -> y falls to 0 within 3 cycles.
- Mid-stream reset plus gaps: x_valid toggling 1/0 with an impulse; assert reset for 1 cycle mid-pipe -> y=0, y_valid=0 next cycle, coefficients cleared. y_valid count equals accepted samples after reset.
